// File: rtl/ips2l_uart_regbank_ctrl.sv
// rtl/ips2l_uart_regbank_ctrl.sv - UART byte-protocol register bank with external status reads
//
// Purpose:
//   Parses command frames from the UART RX byte stream and answers on the TX byte stream.
//     write : A5, addr, NB data bytes (LSB first) -> response 06 (addr in range) or 15
//     read  : 5A, addr                            -> NB response bytes (LSB first)
//   Reads of in-range addresses return a control register. Reads of out-of-range addresses
//   are forwarded to the external status port through a read_req/read_ack handshake.
//   A frame that stalls for TIMEOUT_CYC cycles between bytes is abandoned.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rx_byte, rx_valid, rx_ready     byte stream from the UART RX FIFO
//   tx_byte, tx_valid, tx_ready     byte stream to the UART TX FIFO
//   read_req, read_ack              external status read handshake
//   uart_rd_addr, status_bus        external status address / returned data
//   ctrl_bus                        flattened control registers, register i at [i*DATA_W +: DATA_W]
//   err_timeout                     one-cycle pulse when a frame is abandoned
module ips2l_uart_regbank_ctrl #(
   parameter int                          NUM_REGS    = 15,
   parameter int                          DATA_W      = 32,
   parameter logic [15:0]                 TIMEOUT_CYC = 16'd50000,
   parameter logic [NUM_REGS*DATA_W-1:0]  DFT_VALUE   = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   rx_byte,
   input  logic                         rx_valid,
   output logic                         rx_ready,
   output logic [7:0]                   tx_byte,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         read_req,
   input  logic                         read_ack,
   output logic [7:0]                   uart_rd_addr,
   input  logic [DATA_W-1:0]            status_bus,
   output logic [NUM_REGS*DATA_W-1:0]   ctrl_bus,
   output logic                         err_timeout
);

   localparam int         NB      = DATA_W / 8;
   localparam logic [7:0] CMD_WR  = 8'hA5;
   localparam logic [7:0] CMD_RD  = 8'h5A;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_WEXEC,
      S_RREQ,
      S_RLOAD,
      S_TXRESP
   } state_t;

   state_t                       state;
   state_t                       state_nxt;

   logic                         rx_ready_q;
   logic                         rx_fire;
   logic                         tx_fire;
   logic                         is_write_q;
   logic [7:0]                   addr_q;
   logic [3:0]                   byte_cnt;
   logic [DATA_W-1:0]            wdata_q;
   logic [DATA_W-1:0]            cap_q;
   logic [DATA_W-1:0]            resp_q;
   logic [DATA_W-1:0]            reg_rd;
   logic [3:0]                   resp_left;
   logic [15:0]                  tmo_cnt;
   logic                         tmo_hit;
   logic                         in_frame;
   logic                         addr_in_range;
   logic                         rx_addr_in_range;
   logic [NUM_REGS*DATA_W-1:0]   ctrl_q;

   assign rx_fire          = rx_valid & rx_ready_q;
   assign tx_fire          = tx_valid & tx_ready;

   assign rx_ready         = rx_ready_q;
   assign tx_valid         = (state == S_TXRESP);
   assign tx_byte          = resp_q[7:0];
   assign read_req         = (state == S_RREQ);
   // addr_q only changes on an accepted address byte, which cannot happen in RREQ,
   // so the external address is stable for the whole handshake.
   assign uart_rd_addr     = addr_q;
   assign ctrl_bus         = ctrl_q;

   assign addr_in_range    = (int'(addr_q) < NUM_REGS);
   assign rx_addr_in_range = (int'(rx_byte) < NUM_REGS);
   assign in_frame         = (state == S_ADDR) || (state == S_WDATA);

   // An accepted byte in the expiry cycle takes priority over the timeout.
   assign tmo_hit          = in_frame && !rx_fire && (tmo_cnt == TIMEOUT_CYC - 16'd1);

   always_comb begin
      reg_rd = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(addr_q) == i) begin
            reg_rd = ctrl_q[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (rx_fire && ((rx_byte == CMD_WR) || (rx_byte == CMD_RD))) begin
               state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            if (rx_fire) begin
               if (is_write_q) begin
                  state_nxt = S_WDATA;
               end else if (rx_addr_in_range) begin
                  state_nxt = S_RLOAD;
               end else begin
                  state_nxt = S_RREQ;
               end
            end else if (tmo_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_WDATA: begin
            if (rx_fire && (byte_cnt == 4'(NB - 1))) begin
               state_nxt = S_WEXEC;
            end else if (tmo_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_WEXEC: begin
            state_nxt = S_TXRESP;
         end
         S_RREQ: begin
            if (read_ack) begin
               state_nxt = S_RLOAD;
            end
         end
         S_RLOAD: begin
            state_nxt = S_TXRESP;
         end
         S_TXRESP: begin
            if (tx_fire && (resp_left == 4'd1)) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ready_q  <= 1'b0;
         err_timeout <= 1'b0;
         tmo_cnt     <= 16'd0;
         is_write_q  <= 1'b0;
         addr_q      <= 8'd0;
         byte_cnt    <= 4'd0;
         wdata_q     <= '0;
         cap_q       <= '0;
         resp_q      <= '0;
         resp_left   <= 4'd0;
         ctrl_q      <= DFT_VALUE;
      end else begin
         // Registered from the next state so rx_ready stays low through reset and
         // is already high in the first IDLE cycle after a response completes.
         rx_ready_q  <= (state_nxt == S_IDLE) || (state_nxt == S_ADDR) || (state_nxt == S_WDATA);
         err_timeout <= tmo_hit;

         if (in_frame && !rx_fire && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end else begin
            tmo_cnt <= 16'd0;
         end

         case (state)
            S_IDLE: begin
               if (rx_fire) begin
                  is_write_q <= (rx_byte == CMD_WR);
                  byte_cnt   <= 4'd0;
               end
            end
            S_ADDR: begin
               if (rx_fire) begin
                  addr_q <= rx_byte;
               end
            end
            S_WDATA: begin
               if (rx_fire) begin
                  for (int b = 0; b < NB; b++) begin
                     if (byte_cnt == 4'(b)) begin
                        wdata_q[b*8 +: 8] <= rx_byte;
                     end
                  end
                  byte_cnt <= byte_cnt + 4'd1;
               end
            end
            S_WEXEC: begin
               if (addr_in_range) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (int'(addr_q) == i) begin
                        ctrl_q[i*DATA_W +: DATA_W] <= wdata_q;
                     end
                  end
                  resp_q <= DATA_W'(RSP_ACK);
               end else begin
                  resp_q <= DATA_W'(RSP_NAK);
               end
               resp_left <= 4'd1;
            end
            S_RREQ: begin
               if (read_ack) begin
                  cap_q <= status_bus;
               end
            end
            S_RLOAD: begin
               resp_q    <= addr_in_range ? reg_rd : cap_q;
               resp_left <= 4'(NB);
            end
            S_TXRESP: begin
               if (tx_fire) begin
                  resp_q    <= resp_q >> 8;
                  resp_left <= resp_left - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ips2l_uart_regbank_ctrl.sv
// tb/tb_ips2l_uart_regbank_ctrl.sv - directed scoreboard bench for ips2l_uart_regbank_ctrl
module tb_ips2l_uart_regbank_ctrl;

   localparam int          NREG   = 15;
   localparam int          DW     = 32;
   localparam logic [15:0] TB_TMO = 16'd20;

   function automatic logic [NREG*DW-1:0] mk_dft();
      logic [NREG*DW-1:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++) begin
         v[i*DW +: DW] = 32'hD000_0000 | (i * 32'h0001_0101);
      end
      return v;
   endfunction

   localparam logic [NREG*DW-1:0] DFT = mk_dft();

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [7:0]            rx_byte;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [7:0]            tx_byte;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  read_req;
   logic                  read_ack;
   logic [7:0]            uart_rd_addr;
   logic [DW-1:0]         status_bus;
   logic [NREG*DW-1:0]    ctrl_bus;
   logic                  err_timeout;

   int                    checks   = 0;
   int                    failures = 0;
   logic [7:0]            exp_q[$];
   logic [DW-1:0]         model[NREG];
   logic [7:0]            mon_addr = 8'h00;
   int                    rr_cycles   = 0;
   int                    rd_addr_bad = 0;
   int                    tmo_pulses  = 0;

   always #5 clk = ~clk;

   ips2l_uart_regbank_ctrl #(
      .NUM_REGS    (NREG),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TB_TMO),
      .DFT_VALUE   (DFT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_byte      (tx_byte),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .read_req     (read_req),
      .read_ack     (read_ack),
      .uart_rd_addr (uart_rd_addr),
      .status_bus   (status_bus),
      .ctrl_bus     (ctrl_bus),
      .err_timeout  (err_timeout)
   );

   always @(negedge clk) begin
      if (read_req === 1'b1) begin
         rr_cycles++;
         if (uart_rd_addr !== mon_addr) rd_addr_bad++;
      end
      if (err_timeout === 1'b1) tmo_pulses++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREG*DW-1:0] model_img();
      logic [NREG*DW-1:0] v;
      for (int i = 0; i < NREG; i++) v[i*DW +: DW] = model[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) model[i] = DFT[i*DW +: DW];
   endtask

   task automatic chk_ctrl(input string tag);
      logic [NREG*DW-1:0] e;
      e = model_img();
      checks++;
      assert (ctrl_bus === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, ctrl_bus, e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_byte  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_write(input logic [7:0] a, input logic [DW-1:0] d);
      send_byte(8'hA5);
      send_byte(a);
      for (int b = 0; b < DW/8; b++) send_byte(d[b*8 +: 8]);
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      for (int b = 0; b < DW/8; b++) exp_q.push_back(d[b*8 +: 8]);
   endtask

   // Drains n response bytes against the scoreboard. With b2b set, a command byte is
   // presented alongside the last response byte so it is pending when TXRESP exits.
   task automatic recv_tx(input int n, input bit b2b, input logic [7:0] cmd);
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         tx_ready = 1'b1;
         while (tx_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
         end
         chk("tx_valid", {63'd0, tx_valid}, 64'd1);
         chk("sb_nonempty", {63'd0, (exp_q.size() > 0)}, 64'd1);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
         chk("tx_byte", {56'd0, tx_byte}, {56'd0, e});
         if (b2b && i == n - 1) begin
            rx_byte  = cmd;
            rx_valid = 1'b1;
         end
         @(negedge clk);
      end
      tx_ready = 1'b0;
   endtask

   initial begin
      int rr0;
      int tp0;
      int hit_at;
      int w;

      rst_n      = 1'b0;
      rx_byte    = 8'h00;
      rx_valid   = 1'b0;
      tx_ready   = 1'b0;
      read_ack   = 1'b0;
      status_bus = 32'h0;
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rx_ready",   {63'd0, rx_ready},    64'd0);
      chk("rst_tx_valid",   {63'd0, tx_valid},    64'd0);
      chk("rst_read_req",   {63'd0, read_req},    64'd0);
      chk("rst_err_tmo",    {63'd0, err_timeout}, 64'd0);
      chk("rst_tx_byte",    {56'd0, tx_byte},     64'd0);
      chk("rst_rd_addr",    {56'd0, uart_rd_addr}, 64'd0);
      chk_ctrl("rst_ctrl");
      rst_n = 1'b1;
      @(negedge clk);

      // Write register 3, response held through a TX stall
      rr0 = rr_cycles;
      tp0 = tmo_pulses;
      send_write(8'h03, 32'h12345678);
      chk_ctrl("wr3_before_wexec");
      @(negedge clk);
      model[3] = 32'h12345678;
      chk_ctrl("wr3_ctrl");
      exp_q.push_back(8'h06);
      repeat (TB_TMO + 5) @(negedge clk);
      chk("stall_tx_valid", {63'd0, tx_valid}, 64'd1);
      chk("stall_tx_byte",  {56'd0, tx_byte},  64'h06);
      chk("stall_no_tmo",   tmo_pulses - tp0,  64'd0);
      recv_tx(1, 1'b0, 8'h00);

      // Internal read of register 3
      send_byte(8'h5A);
      send_byte(8'h03);
      push_word(32'h12345678);
      recv_tx(4, 1'b0, 8'h00);
      chk("rd3_no_read_req", rr_cycles - rr0, 64'd0);

      // External read of address 0x20, ack after 5 cycles
      mon_addr = 8'h20;
      rr0 = rr_cycles;
      send_byte(8'h5A);
      send_byte(8'h20);
      w = 0;
      while (read_req !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ext_read_req", {63'd0, read_req}, 64'd1);
      repeat (5) @(negedge clk);
      chk("ext_req_held", {63'd0, read_req}, 64'd1);
      read_ack   = 1'b1;
      status_bus = 32'hCAFEF00D;
      @(negedge clk);
      read_ack   = 1'b0;
      status_bus = 32'h0BADBEEF;
      chk("ext_req_drop",  {63'd0, read_req}, 64'd0);
      chk("ext_addr_stable", rd_addr_bad, 64'd0);
      chk("ext_req_cycles", rr_cycles - rr0, 64'd6);
      push_word(32'hCAFEF00D);
      recv_tx(4, 1'b0, 8'h00);
      chk_ctrl("ext_ctrl");

      // Out-of-range write
      send_write(8'h0F, 32'hAABBCCDD);
      exp_q.push_back(8'h15);
      recv_tx(1, 1'b0, 8'h00);
      chk_ctrl("oor_ctrl");

      // Timeout mid-data
      tp0 = tmo_pulses;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h11);
      hit_at = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (err_timeout === 1'b1 && hit_at == 0) hit_at = k;
      end
      chk("tmo_latency", hit_at, 64'(TB_TMO));
      chk("tmo_one_pulse", tmo_pulses - tp0, 64'd1);
      chk("tmo_idle_ready", {63'd0, rx_ready}, 64'd1);
      chk_ctrl("tmo_ctrl");
      send_byte(8'h5A);
      send_byte(8'h02);
      push_word(DFT[2*DW +: DW]);
      recv_tx(4, 1'b0, 8'h00);

      // Byte arriving in the expiry cycle wins
      tp0 = tmo_pulses;
      send_byte(8'hA5);
      repeat (TB_TMO - 1) @(negedge clk);
      send_byte(8'h04);
      for (int b = 0; b < 4; b++) send_byte(8'h44 - 8'(b * 8'h11));
      exp_q.push_back(8'h06);
      recv_tx(1, 1'b0, 8'h00);
      model[4] = 32'h11223344;
      chk("win_no_tmo", tmo_pulses - tp0, 64'd0);
      chk_ctrl("win_ctrl");

      // Back-to-back frames: next command pending while the last response byte leaves
      send_byte(8'h5A);
      send_byte(8'h04);
      push_word(32'h11223344);
      recv_tx(4, 1'b1, 8'h5A);
      chk("b2b_rx_ready", {63'd0, rx_ready}, 64'd1);
      @(negedge clk);
      rx_valid = 1'b0;
      send_byte(8'h03);
      push_word(32'h12345678);
      recv_tx(4, 1'b0, 8'h00);

      // Reset asserted during RREQ
      mon_addr = 8'h21;
      send_byte(8'h5A);
      send_byte(8'h21);
      w = 0;
      while (read_req !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("rrq_reached", {63'd0, read_req}, 64'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_mid_read_req", {63'd0, read_req}, 64'd0);
      chk("rst_mid_rx_ready", {63'd0, rx_ready}, 64'd0);
      chk_ctrl("rst_mid_ctrl");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_write(8'h00, 32'h00000001);
      exp_q.push_back(8'h06);
      recv_tx(1, 1'b0, 8'h00);
      model[0] = 32'h00000001;
      chk_ctrl("post_rst_ctrl");
      chk("sb_drained", exp_q.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/ips2l_uart_regbank_ctrl.md
IPS2L_UART_REGBANK_CTRL -- requirements
Module: ips2l_uart_regbank_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 15, meaning number of writable control registers (1..128).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register width in bits (multiple of 8, 8..64); NB = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16'd50000, meaning idle cycles allowed between bytes of one frame (>=2).
REQ-004 SHALL have parameter DFT_VALUE, default all-zero, meaning NUM_REGS*DATA_W reset image, with register i at bits [i*DATA_W +: DATA_W].
REQ-005 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports rx_byte  input  8, rx_valid  input  1, and rx_ready  output  1, forming the byte stream from the UART RX FIFO.
REQ-008 SHALL have ports tx_byte  output  8, tx_valid  output  1, and tx_ready  input  1, forming the byte stream to the UART TX FIFO.
REQ-009 SHALL have ports read_req  output  1, read_ack  input  1, uart_rd_addr  output  8, and status_bus  input  DATA_W, forming the external status read handshake.
REQ-010 SHALL have port ctrl_bus  output  NUM_REGS*DATA_W  flattened control registers.
REQ-011 SHALL have port err_timeout  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-012 SHALL count a byte transfer only on a cycle where valid and ready are both high, on both streams.
REQ-013 SHALL accept frames of the form: command byte, then address byte, then NB data bytes for writes only; data is LSB first.
REQ-014 SHALL use command 8'hA5 for write and 8'h5A for read; any other byte in IDLE SHALL be consumed and discarded.
REQ-015 SHALL use states IDLE, ADDR, WDATA, WEXEC, RREQ, RLOAD, and TXRESP.
- IDLE->ADDR on a valid command.
- ADDR->WDATA for a write; ADDR->RREQ or RLOAD for a read.
- WDATA->WEXEC after NB bytes.
- WEXEC->TXRESP.
- RREQ->RLOAD on read_ack.
- RLOAD->TXRESP.
- TXRESP->IDLE after the last response byte.
REQ-016 SHALL drive rx_ready high only in IDLE, ADDR, and WDATA.
REQ-017 On a write with addr < NUM_REGS, SHALL update the register one cycle after the last data byte (in WEXEC), then send response byte 8'h06.
REQ-018 On a write with addr >= NUM_REGS, SHALL leave all registers unchanged and send response 8'h15.
REQ-019 On a read with addr < NUM_REGS, SHALL load the register internally without asserting read_req, then send NB bytes LSB first.
REQ-020 On a read with addr >= NUM_REGS, SHALL assert read_req and hold uart_rd_addr = addr until the cycle read_ack is sampled high, capture status_bus in that cycle, deassert read_req the next cycle, then send NB bytes.
REQ-021 SHALL hold uart_rd_addr stable whenever read_req is high; read_ack while read_req is low SHALL be ignored.
REQ-022 In TXRESP, SHALL hold tx_valid high with tx_byte stable until accepted; tx_ready low SHALL stall indefinitely with no timeout.
REQ-023 SHALL start a timeout counter on entry to ADDR or WDATA and clear it on every accepted byte.
REQ-024 When the timeout counter reaches TIMEOUT_CYC-1, SHALL return to IDLE, pulse err_timeout for 1 cycle, and modify no register.
REQ-025 A byte accepted in the same cycle the timeout expires SHALL win: the counter clears and no timeout occurs.
REQ-026 Back-to-back frames SHALL be supported: a command byte present in the cycle after TXRESP exits SHALL be accepted.
REQ-027 SHALL make ctrl_bus purely registered, changing only in WEXEC.

Reset
REQ-028 On rst_n low, SHALL immediately force:
- state IDLE;
- ctrl_bus = DFT_VALUE;
- rx_ready, tx_valid, read_req, and err_timeout = 0;
- tx_byte, uart_rd_addr, and the timeout counter = 0.
REQ-029 Reset mid-frame or mid-handshake SHALL discard partial data; the first frame after release SHALL parse normally.

Verification
REQ-030 Write A5,03,78,56,34,12 -> ctrl_bus[127:96]=32'h12345678 in WEXEC, single tx byte 06, other registers unchanged.
REQ-031 Read 5A,03 after REQ-030 -> tx bytes 78,56,34,12 with read_req never asserted.
REQ-032 Read 5A,20 with read_ack after 5 cycles and status_bus=32'hCAFEF00D -> uart_rd_addr=8'h20 stable during read_req, tx bytes 0D,F0,FE,CA.
REQ-033 Write A5,0F,... with NUM_REGS=15 -> tx byte 15, ctrl_bus unchanged.
REQ-034 A5,02,11 then silence for TIMEOUT_CYC cycles -> err_timeout pulse, register 2 unchanged, and a following read of register 2 returns its DFT_VALUE.
REQ-035 Assert rst_n low during RREQ, then release and send A5,00,01,00,00,00 -> read_req=0 immediately, all registers at DFT_VALUE, then register 0 = 1 and response 06.
